// File: rtl/dcm_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Channel select width, parameter limits, channel state encoding.
package dcm_pkg;

    localparam int unsigned CH_SEL_W   = 3;
    localparam int unsigned PROG_W_MAX = 4;
    localparam int unsigned NUM_CH_MAX = 8;

    typedef enum logic {
        CH_RUN   = 1'b0,
        CH_ARMED = 1'b1
    } chan_state_e;

    // System clock cycles per half period of the base clock.
    function automatic int unsigned half_count(input int unsigned freq, input int unsigned base);
        return freq / (2 * base);
    endfunction

endpackage

// File: rtl/dcm_chan.sv
// One programmable divider channel: divides the base half-period strobe by 2^act.
// A new setting is staged and takes effect only on the channel's next rising edge.
module dcm_chan
    import dcm_pkg::*;
#(
    parameter int unsigned PROG_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_bhalf,
    input  logic              i_update,
    input  logic [PROG_W-1:0] i_prog,
    output logic              o_clk,
    output logic              o_tick,
    output logic [PROG_W-1:0] o_act,
    output logic              o_pending
);

    localparam int unsigned HCNT_W = 2 ** PROG_W;

    logic [HCNT_W-1:0] r_hcnt;
    logic [PROG_W-1:0] r_act;
    logic [PROG_W-1:0] r_stg;
    chan_state_e       r_state;
    logic              r_clk;
    logic              r_tick;

    logic [HCNT_W-1:0] w_hmax;
    logic              w_toggle;
    logic              w_rise;

    assign w_hmax   = (HCNT_W'(1) << r_act) - HCNT_W'(1);
    assign w_toggle = i_bhalf && (r_hcnt == w_hmax);
    assign w_rise   = w_toggle && !r_clk;

    // Apply happens on the rising toggle; a coincident update restages and keeps the channel armed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt  <= '0;
            r_act   <= '0;
            r_stg   <= '0;
            r_state <= CH_RUN;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= w_rise;
            if (w_toggle) begin
                r_clk  <= ~r_clk;
                r_hcnt <= '0;
            end else if (i_bhalf) begin
                r_hcnt <= r_hcnt + HCNT_W'(1);
            end
            case (r_state)
                CH_RUN: begin
                    if (i_update) begin
                        r_stg   <= i_prog;
                        r_state <= CH_ARMED;
                    end
                end
                CH_ARMED: begin
                    if (w_rise) begin
                        r_act   <= r_stg;
                        r_state <= CH_RUN;
                    end
                    if (i_update) begin
                        r_stg   <= i_prog;
                        r_state <= CH_ARMED;
                    end
                end
                default: r_state <= CH_RUN;
            endcase
        end
    end

    assign o_clk     = r_clk;
    assign o_tick    = r_tick;
    assign o_act     = r_act;
    assign o_pending = (r_state == CH_ARMED);

endmodule

// File: rtl/dcm_multi.sv
// Multi-channel clock generator: fixed base clock plus NUM_CH channels at BASE_HZ/2^k.
// Holds the shared base half-period counter and the channel select decode.
module dcm_multi
    import dcm_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BASE_HZ     = 10,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned PROG_W      = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     update,
    input  logic [CH_SEL_W-1:0]      ch_sel,
    input  logic [PROG_W-1:0]        prog_in,
    output logic                     clk_1,
    output logic [NUM_CH-1:0]        clk_2,
    output logic [NUM_CH-1:0]        tick_2,
    output logic [NUM_CH*PROG_W-1:0] prog_out,
    output logic [NUM_CH-1:0]        pending
);

    localparam int unsigned HALF   = half_count(CLK_FREQ_HZ, BASE_HZ);
    localparam int unsigned BCNT_W = (HALF > 1) ? $clog2(HALF) : 1;

    generate
        if (HALF < 2) begin : g_bad_half
            $error("dcm_multi: CLK_FREQ_HZ/(2*BASE_HZ) must be at least 2");
        end
        if (NUM_CH < 1 || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
            $error("dcm_multi: NUM_CH must be 1..8");
        end
        if (PROG_W < 1 || PROG_W > PROG_W_MAX) begin : g_bad_prog_w
            $error("dcm_multi: PROG_W must be 1..4");
        end
    endgenerate

    logic [BCNT_W-1:0] r_bcnt;
    logic              r_clk1;
    logic              w_bhalf;
    logic [NUM_CH-1:0] w_upd;

    assign w_bhalf = (r_bcnt == BCNT_W'(HALF - 1));

    // Base counter: one bhalf strobe every HALF cycles drives clk_1 and all channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcnt <= '0;
            r_clk1 <= 1'b0;
        end else if (w_bhalf) begin
            r_bcnt <= '0;
            r_clk1 <= ~r_clk1;
        end else begin
            r_bcnt <= r_bcnt + BCNT_W'(1);
        end
    end

    assign clk_1 = r_clk1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Selects beyond NUM_CH never match and are dropped.
            assign w_upd[gi] = update && (ch_sel == CH_SEL_W'(gi));

            dcm_chan #(
                .PROG_W (PROG_W)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .i_bhalf   (w_bhalf),
                .i_update  (w_upd[gi]),
                .i_prog    (prog_in),
                .o_clk     (clk_2[gi]),
                .o_tick    (tick_2[gi]),
                .o_act     (prog_out[gi*PROG_W +: PROG_W]),
                .o_pending (pending[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_dcm_multi.sv
// Bench for dcm_multi: an event-level reference pushes the expected output vector
// each cycle; each scenario pops it and compares against the sampled DUT outputs.
module tb_dcm_multi;

    localparam int unsigned CLK_FREQ_HZ = 20;
    localparam int unsigned BASE_HZ     = 1;
    localparam int unsigned NUM_CH      = 3;
    localparam int unsigned PROG_W      = 3;
    localparam int          HALF        = 10;
    localparam int unsigned VW          = 1 + 3 * NUM_CH + NUM_CH * PROG_W;

    logic                     clk;
    logic                     rst;
    logic                     update;
    logic [2:0]               ch_sel;
    logic [PROG_W-1:0]        prog_in;
    logic                     clk_1;
    logic [NUM_CH-1:0]        clk_2;
    logic [NUM_CH-1:0]        tick_2;
    logic [NUM_CH*PROG_W-1:0] prog_out;
    logic [NUM_CH-1:0]        pending;

    dcm_multi #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BASE_HZ     (BASE_HZ),
        .NUM_CH      (NUM_CH),
        .PROG_W      (PROG_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .update   (update),
        .ch_sel   (ch_sel),
        .prog_in  (prog_in),
        .clk_1    (clk_1),
        .clk_2    (clk_2),
        .tick_2   (tick_2),
        .prog_out (prog_out),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run;
    int n_fail;

    // Reference state: t counts cycles since the last reset edge; each channel is
    // described by its last rise time, active setting and staged request.
    int t;
    int m_r   [NUM_CH];
    int m_k   [NUM_CH];
    int m_stg [NUM_CH];
    bit m_pend[NUM_CH];

    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] e;

    function automatic logic [VW-1:0] obs();
        return {clk_1, clk_2, tick_2, prog_out, pending};
    endfunction

    function automatic int period(input int ch);
        return (2 * HALF) << m_k[ch];
    endfunction

    function automatic int next_rise(input int ch);
        if (t < m_r[ch]) return m_r[ch];
        return m_r[ch] + ((t - m_r[ch]) / period(ch) + 1) * period(ch);
    endfunction

    function automatic int phase(input int ch);
        if (t < m_r[ch]) return -1;
        return (t - m_r[ch]) % period(ch);
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic                     c1;
        logic [NUM_CH-1:0]        c2;
        logic [NUM_CH-1:0]        tk;
        logic [NUM_CH-1:0]        pd;
        logic [NUM_CH*PROG_W-1:0] po;
        c1 = ((t / HALF) % 2) == 1;
        c2 = '0;
        tk = '0;
        pd = '0;
        po = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (t >= m_r[i]) begin
                c2[i] = ((t - m_r[i]) % period(i)) < (period(i) / 2);
                tk[i] = ((t - m_r[i]) % period(i)) == 0;
            end
            po[i*PROG_W +: PROG_W] = PROG_W'(m_k[i]);
            pd[i] = m_pend[i];
        end
        return {c1, c2, tk, po, pd};
    endfunction

    // Advance one clock; inputs seen at the edge are the ones driven before the call.
    task automatic tick();
        logic       r;
        logic       u;
        logic [2:0] s;
        logic [2:0] p;
        r = rst;
        u = update;
        s = ch_sel;
        p = prog_in;
        @(posedge clk);
        #1;
        if (r) begin
            t = 0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                m_r[i]    = HALF;
                m_k[i]    = 0;
                m_stg[i]  = 0;
                m_pend[i] = 1'b0;
            end
        end else begin
            t++;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (m_pend[i] && t >= m_r[i] && ((t - m_r[i]) % period(i)) == 0) begin
                    m_k[i]    = m_stg[i];
                    m_r[i]    = t;
                    m_pend[i] = 1'b0;
                end
            end
            if (u && int'(s) < int'(NUM_CH)) begin
                m_stg[int'(s)]  = int'(p);
                m_pend[int'(s)] = 1'b1;
            end
        end
        exp_q.push_back(model_vec());
    endtask

    task automatic test_reset();
        rst = 1'b1;
        update = 1'b0;
        ch_sel = '0;
        prog_in = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL reset_hold t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL reset_release t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
    endtask

    task automatic test_default();
        for (int i = 0; i < 50; i++) begin
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL default_run t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
    endtask

    task automatic test_reprogram();
        for (int g = 0; g < 100 && phase(1) != 3; g++) begin
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL reprog_align t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
        n_run++;
        if (phase(1) != 3) begin
            n_fail++;
            $display("FAIL reprog_align_timeout t=%0d phase=%0d exp=3", t, phase(1));
        end
        update = 1'b1;
        ch_sel = 3'd1;
        prog_in = 3'd2;
        tick();
        update = 1'b0;
        e = exp_q.pop_front();
        n_run++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reprog_pending t=%0d got=%h exp=%h", t, obs(), e);
        end
        for (int i = 0; i < 200; i++) begin
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL reprog_run t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int g = 0; g < 100 && phase(0) != 3; g++) begin
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL b2b_align t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
        update = 1'b1;
        ch_sel = 3'd0;
        prog_in = 3'd5;
        tick();
        prog_in = 3'd3;
        e = exp_q.pop_front();
        n_run++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL b2b_first t=%0d got=%h exp=%h", t, obs(), e);
        end
        tick();
        update = 1'b0;
        e = exp_q.pop_front();
        n_run++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL b2b_second t=%0d got=%h exp=%h", t, obs(), e);
        end
        for (int g = 0; g < 100 && next_rise(0) != t + 1; g++) begin
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL b2b_wait t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
        n_run++;
        if (next_rise(0) != t + 1) begin
            n_fail++;
            $display("FAIL b2b_wait_timeout t=%0d next=%0d exp=%0d", t, next_rise(0), t + 1);
        end
        update = 1'b1;
        ch_sel = 3'd0;
        prog_in = 3'd1;
        tick();
        update = 1'b0;
        e = exp_q.pop_front();
        n_run++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL b2b_coincident t=%0d got=%h exp=%h", t, obs(), e);
        end
        for (int i = 0; i < 360; i++) begin
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL b2b_run t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
    endtask

    task automatic test_invalid_sel();
        logic [2:0] bad_sel[3];
        bad_sel[0] = 3'd5;
        bad_sel[1] = 3'd3;
        bad_sel[2] = 3'd7;
        for (int i = 0; i < 3; i++) begin
            update = 1'b1;
            ch_sel = bad_sel[i];
            prog_in = 3'(4 + i);
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL invalid_sel sel=%0d t=%0d got=%h exp=%h", bad_sel[i], t, obs(), e);
            end
        end
        update = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL invalid_run t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int g = 0; g < 100 && phase(2) != 2; g++) begin
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL rstmid_align t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
        update = 1'b1;
        ch_sel = 3'd2;
        prog_in = 3'd7;
        tick();
        update = 1'b0;
        e = exp_q.pop_front();
        n_run++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL rstmid_arm t=%0d got=%h exp=%h", t, obs(), e);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL rstmid_armed t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e = exp_q.pop_front();
        n_run++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL rstmid_clear got=%h exp=%h", obs(), e);
        end
        for (int i = 0; i < 25; i++) begin
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL rstmid_restart t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        t = 0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            m_r[i]    = HALF;
            m_k[i]    = 0;
            m_stg[i]  = 0;
            m_pend[i] = 1'b0;
        end
        rst = 1'b1;
        update = 1'b0;
        ch_sel = '0;
        prog_in = '0;
        test_reset();
        test_default();
        test_reprogram();
        test_back_to_back();
        test_invalid_sel();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
